// File: rtl/day11_path_counter.sv
// rtl/day11_path_counter.sv - DAG path counter: edge-list store, per-query DP over topologically numbered nodes
// Results leave as a count/count_valid/count_last stream with unlimited backpressure.
module day11_path_counter #(
  parameter int NODE_BITS = 10,
  parameter int EDGE_BITS = 12,
  parameter int WIDTH     = 64
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 load,
  input  logic                 edge_valid,
  input  logic [NODE_BITS-1:0] edge_src,
  input  logic [NODE_BITS-1:0] edge_dst,
  output logic                 edge_ready,
  output logic                 edge_overflow,
  input  logic                 query_valid,
  input  logic [NODE_BITS-1:0] query_src,
  input  logic [NODE_BITS-1:0] query_dst,
  input  logic                 query_last,
  output logic                 query_ready,
  output logic [WIDTH-1:0]     count,
  output logic                 count_valid,
  output logic                 count_last,
  input  logic                 count_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, SWEEP, EMIT} state_t;

  state_t state, next_state;

  logic [EDGE_BITS:0]       ecount;
  logic [2*NODE_BITS-1:0]   edge_mem [2**EDGE_BITS];
  logic [WIDTH-1:0]         path_mem [2**NODE_BITS];
  logic [NODE_BITS-1:0]     q_src, q_dst, node_idx;
  logic [EDGE_BITS-1:0]     edge_idx;
  logic                     q_last;
  logic                     edge_full, edge_take, clear_done, sweep_done;
  logic [NODE_BITS-1:0]     sw_src, sw_dst;

  // ecount's top bit alone means the store holds exactly 2**EDGE_BITS edges
  assign edge_full   = ecount[EDGE_BITS];
  assign edge_take   = edge_valid & edge_ready;
  assign {sw_src, sw_dst} = edge_mem[edge_idx];
  assign clear_done  = &node_idx;
  assign sweep_done  = ({1'b0, edge_idx} == ecount - (EDGE_BITS+1)'(1));

  assign edge_ready  = (state == IDLE) & ~query_valid & ~load;
  assign query_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign count_valid = (state == EMIT);
  assign count_last  = q_last;
  assign count       = (state == EMIT) ? path_mem[q_dst] : '0;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (query_valid) next_state = CLEAR;
      CLEAR:   if (clear_done) next_state = (ecount != '0) ? SWEEP : EMIT;
      SWEEP:   if (sweep_done) next_state = EMIT;
      EMIT:    if (count_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      ecount        <= '0;
      edge_overflow <= 1'b0;
      q_src         <= '0;
      q_dst         <= '0;
      q_last        <= 1'b0;
      node_idx      <= '0;
      edge_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            ecount        <= '0;
            edge_overflow <= 1'b0;
          end else if (edge_take) begin
            if (edge_full) edge_overflow <= 1'b1;
            else           ecount <= ecount + (EDGE_BITS+1)'(1);
          end
          if (query_valid) begin
            q_src    <= query_src;
            q_dst    <= query_dst;
            q_last   <= query_last;
            node_idx <= '0;
          end
        end
        CLEAR: begin
          node_idx <= node_idx + NODE_BITS'(1);
          edge_idx <= '0;
        end
        SWEEP:   edge_idx <= edge_idx + EDGE_BITS'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear_n && edge_take && !edge_full) begin
      edge_mem[ecount[EDGE_BITS-1:0]] <= {edge_src, edge_dst};
    end
  end

  // Edges arrive sorted by source, so each source total is final before it is propagated
  always_ff @(posedge clock) begin
    if (clear_n) begin
      if (state == CLEAR) begin
        path_mem[node_idx] <= (node_idx == q_src) ? WIDTH'(1) : '0;
      end else if (state == SWEEP) begin
        path_mem[sw_dst] <= path_mem[sw_dst] + path_mem[sw_src];
      end
    end
  end

endmodule
